// File: rtl/riscv_imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// riscv_imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - default data width and imem byte-address width
//   - loader state encoding (exported so a debug top can decode the state)
//   - helper that turns an imem byte-address width into a word depth
// -----------------------------------------------------------------------------
package riscv_imem_loader_pkg;

   localparam int XLEN_DEF          = 32;
   localparam int IMEM_ADDR_BIT_DEF = 12;

   // Explicit encodings so external debug logic can decode the state value.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN_RX  = 3'd1,
      ST_DATA_RX = 3'd2,
      ST_WR      = 3'd3,
      ST_DONE    = 3'd4,
      ST_ERR     = 3'd5
   } loader_state_e;

   // Number of 32-bit words addressable with a byte address of addr_bit bits.
   function automatic logic [31:0] depth_words(input int addr_bit);
      return 32'd1 << (addr_bit - 2);
   endfunction

endpackage

// File: rtl/riscv_imem_loader_if.sv
// -----------------------------------------------------------------------------
// riscv_imem_loader_if
// Byte-stream input and imem write port of the loader, bundled together.
//   rx_data/rx_valid : byte stream from the receiver
//   rx_ready         : loader accepts a byte this cycle
//   imem_we          : one-cycle write strobe per word
//   imem_addr        : word address
//   imem_wdata       : write word
// modport master : the loader (consumes the stream, drives the imem write)
// modport slave  : its environment (stream source and imem array)
// -----------------------------------------------------------------------------
interface riscv_imem_loader_if #(
   parameter int XLEN          = riscv_imem_loader_pkg::XLEN_DEF,
   parameter int IMEM_ADDR_BIT = riscv_imem_loader_pkg::IMEM_ADDR_BIT_DEF
);

   logic [7:0]               rx_data;
   logic                     rx_valid;
   logic                     rx_ready;
   logic                     imem_we;
   logic [IMEM_ADDR_BIT-3:0] imem_addr;
   logic [XLEN-1:0]          imem_wdata;

   modport master (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );

endinterface

// File: rtl/riscv_imem_loader_byte2word.sv
// -----------------------------------------------------------------------------
// riscv_imem_loader_byte2word
// Little-endian 4-byte assembler. Byte k of a word lands in bits [8k+7:8k].
// The 4th byte is not stored: o_word combines the three held bytes with the
// byte presented this cycle, so o_word is complete in the same cycle that
// o_word_valid pulses.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_clr         : restart at byte 0
//   i_byte_en     : a byte is accepted this cycle
//   i_byte        : the byte
//   o_word        : assembled word (valid when o_word_valid)
//   o_word_valid  : pulses with the 4th accepted byte
// -----------------------------------------------------------------------------
module riscv_imem_loader_byte2word (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_clr,
   input  logic        i_byte_en,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   logic [1:0]  byte_cnt_r;
   logic [23:0] low_bytes_r;

   // Byte counter and storage of the three lower bytes.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         byte_cnt_r  <= 2'd0;
         low_bytes_r <= 24'd0;
      end else if (i_clr) begin
         byte_cnt_r  <= 2'd0;
         low_bytes_r <= 24'd0;
      end else if (i_byte_en) begin
         byte_cnt_r <= byte_cnt_r + 2'd1;
         case (byte_cnt_r)
            2'd0:    low_bytes_r[7:0]   <= i_byte;
            2'd1:    low_bytes_r[15:8]  <= i_byte;
            2'd2:    low_bytes_r[23:16] <= i_byte;
            default: low_bytes_r        <= low_bytes_r;
         endcase
      end
   end

   assign o_word       = {i_byte, low_bytes_r};
   assign o_word_valid = i_byte_en && (byte_cnt_r == 2'd3);

endmodule

// File: rtl/riscv_imem_loader.sv
// -----------------------------------------------------------------------------
// riscv_imem_loader
// Receives a program image (4-byte LE word count LEN, then LEN LE words) over
// a valid/ready byte stream and writes it word by word into the instruction
// memory. Holds the core in reset until a load completes.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_start       : one-cycle pulse starting a load (IDLE, DONE or ERR only)
//   bus           : byte stream in + imem write port out (master modport)
//   o_core_rstn   : active-low core reset, high only in DONE
//   o_done        : load completed
//   o_err         : header length exceeded memory depth
// All outputs are registered; they are decoded from the next state so that
// they line up with the state register.
// -----------------------------------------------------------------------------
module riscv_imem_loader
   import riscv_imem_loader_pkg::*;
#(
   parameter int XLEN          = XLEN_DEF,
   parameter int IMEM_ADDR_BIT = IMEM_ADDR_BIT_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_start,
   riscv_imem_loader_if.master  bus,
   output logic                 o_core_rstn,
   output logic                 o_done,
   output logic                 o_err
);

   localparam int          AW    = IMEM_ADDR_BIT - 2;
   localparam logic [31:0] DEPTH = depth_words(IMEM_ADDR_BIT);

   loader_state_e   state_r;
   loader_state_e   next_state_s;

   logic            accept_s;
   logic            start_ok_s;
   logic [31:0]     word_s;
   logic            word_valid_s;
   logic            last_word_s;

   logic [31:0]     len_r;
   logic [AW-1:0]   word_idx_r;
   logic [AW-1:0]   addr_r;
   logic [XLEN-1:0] wdata_r;

   logic            rx_ready_r;
   logic            we_r;
   logic            done_r;
   logic            core_rstn_r;
   logic            err_r;

   logic            rx_ready_s;
   logic            we_s;
   logic            done_s;
   logic            core_rstn_s;
   logic            err_s;

   assign accept_s   = bus.rx_valid && rx_ready_r;
   assign start_ok_s = i_start && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                   (state_r == ST_ERR));
   // Word index and count advance together, so count+1 == LEN marks the last word.
   assign last_word_s = (({{(32-AW){1'b0}}, word_idx_r} + 32'd1) == len_r);

   riscv_imem_loader_byte2word u_byte2word (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_clr        (start_ok_s),
      .i_byte_en    (accept_s),
      .i_byte       (bus.rx_data),
      .o_word       (word_s),
      .o_word_valid (word_valid_s)
   );

   // State register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (i_start) begin
               next_state_s = ST_LEN_RX;
            end else begin
               next_state_s = state_r;
            end
         end
         ST_LEN_RX: begin
            if (word_valid_s) begin
               if (word_s == 32'd0) begin
                  next_state_s = ST_DONE;
               end else if (word_s > DEPTH) begin
                  next_state_s = ST_ERR;
               end else begin
                  next_state_s = ST_DATA_RX;
               end
            end else begin
               next_state_s = ST_LEN_RX;
            end
         end
         ST_DATA_RX: begin
            if (word_valid_s) begin
               next_state_s = ST_WR;
            end else begin
               next_state_s = ST_DATA_RX;
            end
         end
         ST_WR: begin
            if (last_word_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_DATA_RX;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Output decode from the next state; registered below.
   always_comb begin
      rx_ready_s  = 1'b0;
      we_s        = 1'b0;
      done_s      = 1'b0;
      core_rstn_s = 1'b0;
      err_s       = 1'b0;
      case (next_state_s)
         ST_LEN_RX, ST_DATA_RX: rx_ready_s = 1'b1;
         ST_WR:                 we_s       = 1'b1;
         ST_DONE: begin
            done_s      = 1'b1;
            core_rstn_s = 1'b1;
         end
         ST_ERR:                err_s      = 1'b1;
         default: begin
            rx_ready_s  = 1'b0;
            we_s        = 1'b0;
            done_s      = 1'b0;
            core_rstn_s = 1'b0;
            err_s       = 1'b0;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rx_ready_r  <= 1'b0;
         we_r        <= 1'b0;
         done_r      <= 1'b0;
         core_rstn_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         rx_ready_r  <= rx_ready_s;
         we_r        <= we_s;
         done_r      <= done_s;
         core_rstn_r <= core_rstn_s;
         err_r       <= err_s;
      end
   end

   // Length, word index, and the write address/data captured on entry to WR.
   // addr/wdata are held outside WR; the index advances as WR is left.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         len_r      <= 32'd0;
         word_idx_r <= '0;
         addr_r     <= '0;
         wdata_r    <= '0;
      end else begin
         if ((state_r == ST_LEN_RX) && word_valid_s) begin
            len_r      <= word_s;
            word_idx_r <= '0;
         end else if (state_r == ST_WR) begin
            word_idx_r <= word_idx_r + AW'(1'b1);
         end
         if ((state_r == ST_DATA_RX) && word_valid_s) begin
            addr_r  <= word_idx_r;
            wdata_r <= word_s;
         end
      end
   end

   assign bus.rx_ready   = rx_ready_r;
   assign bus.imem_we    = we_r;
   assign bus.imem_addr  = addr_r;
   assign bus.imem_wdata = wdata_r;
   assign o_core_rstn    = core_rstn_r;
   assign o_done         = done_r;
   assign o_err          = err_r;

endmodule

// File: tb/tb_riscv_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_riscv_imem_loader
// Self-checking bench for riscv_imem_loader. Expected writes follow directly
// from the image: for 1 <= LEN <= DEPTH, word i of the image is written at
// address i; otherwise nothing is written.
// -----------------------------------------------------------------------------
module tb_riscv_imem_loader;
   import riscv_imem_loader_pkg::*;

   localparam int AW    = IMEM_ADDR_BIT_DEF - 2;
   localparam int DEPTH = 1 << AW;

   typedef logic [31:0] word_q_t[$];
   typedef struct {
      int          addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic clk   = 1'b0;
   logic rstn  = 1'b0;
   logic start = 1'b0;
   logic core_rstn, done, err;

   riscv_imem_loader_if bus ();

   riscv_imem_loader dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_start     (start),
      .bus         (bus),
      .o_core_rstn (core_rstn),
      .o_done      (done),
      .o_err       (err)
   );

   always #5 clk = ~clk;

   int  cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: record every imem write and any write with ready high.
   wr_t wr_q[$];
   int  ready_viol = 0;
   always @(negedge clk) begin
      if (bus.imem_we) begin
         wr_q.push_back('{int'(bus.imem_addr), bus.imem_wdata, cyc});
         if (bus.rx_ready) ready_viol++;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   // ---------------- stimulus helpers ----------------
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int w = 0;
      @(negedge clk);
      if (gaps) begin
         while ($urandom_range(0, 1) == 0) begin
            bus.rx_valid = 1'b0;
            @(negedge clk);
         end
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      while (!bus.rx_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         n_chk++; n_fail++;
         $display("FAIL send_byte_timeout: rx_ready=%0b, required 1 within 100 cycles", bus.rx_ready);
      end
      @(posedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic end_stream();
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || err) && n < 64) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (!(done || err)) begin
         n_fail++;
         $display("FAIL wait_end: done=%0b err=%0b, required one of them within 64 cycles", done, err);
      end
   endtask

   task automatic run_load(input logic [31:0] len, input word_q_t words, input bit gaps);
      send_word(len, gaps);
      foreach (words[i]) send_word(words[i], gaps);
      end_stream();
      wait_end();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rstn, done, err} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: ready=%0b we=%0b addr=%0h wdata=%h core_rstn=%0b done=%0b err=%0b, required all 0",
                  bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rstn, done, err);
      end
      rstn = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.rx_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ready: rx_ready=%0b, required 0", bus.rx_ready);
      end
   endtask

   task automatic test_single();
      int base = wr_q.size();
      pulse_start();
      run_load(32'd1, '{32'h00A00513}, 1'b0);
      n_chk++;
      if (wr_q.size() - base !== 1) begin
         n_fail++;
         $display("FAIL single_count: writes=%0d, required 1", wr_q.size() - base);
      end else begin
         n_chk++;
         if (wr_q[base].addr !== 0 || wr_q[base].data !== 32'h00A00513) begin
            n_fail++;
            $display("FAIL single_write: addr=%0d data=%h, required addr=0 data=00a00513",
                     wr_q[base].addr, wr_q[base].data);
         end
      end
      n_chk++;
      if (done !== 1'b1 || core_rstn !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: done=%0b core_rstn=%0b err=%0b, required 1 1 0", done, core_rstn, err);
      end
   endtask

   task automatic test_back_to_back();
      word_q_t words = '{32'h11111111, 32'h22222222, 32'h33333333};
      int base = wr_q.size();
      int rv0  = ready_viol;
      pulse_start();
      run_load(32'd3, words, 1'b0);
      n_chk++;
      if (wr_q.size() - base !== 3) begin
         n_fail++;
         $display("FAIL b2b_count: writes=%0d, required 3", wr_q.size() - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (wr_q[base+i].addr !== i || wr_q[base+i].data !== words[i]) begin
               n_fail++;
               $display("FAIL b2b_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                        i, wr_q[base+i].addr, wr_q[base+i].data, i, words[i]);
            end
         end
         for (int i = 1; i < 3; i++) begin
            n_chk++;
            if (wr_q[base+i].cyc - wr_q[base+i-1].cyc !== 5) begin
               n_fail++;
               $display("FAIL b2b_spacing%0d: %0d cycles, required 5", i, wr_q[base+i].cyc - wr_q[base+i-1].cyc);
            end
         end
      end
      n_chk++;
      if (ready_viol - rv0 !== 0) begin
         n_fail++;
         $display("FAIL b2b_ready_in_wr: %0d writes with rx_ready=1, required 0", ready_viol - rv0);
      end
   endtask

   task automatic test_len_zero();
      int base = wr_q.size();
      pulse_start();
      n_chk++;
      if (done !== 1'b0 || core_rstn !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_restart: done=%0b core_rstn=%0b, required 0 0", done, core_rstn);
      end
      send_word(32'd0, 1'b0);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      n_chk++;
      if (done !== 1'b1 || core_rstn !== 1'b1) begin
         n_fail++;
         $display("FAIL len0_done: done=%0b core_rstn=%0b one cycle after header, required 1 1", done, core_rstn);
      end
      repeat (4) @(negedge clk);
      n_chk++;
      if (wr_q.size() !== base) begin
         n_fail++;
         $display("FAIL len0_writes: writes=%0d, required 0", wr_q.size() - base);
      end
   endtask

   task automatic test_len_overflow();
      int base = wr_q.size();
      pulse_start();
      run_load(DEPTH + 1, '{}, 1'b0);
      repeat (5) @(negedge clk);
      n_chk++;
      if (err !== 1'b1 || core_rstn !== 1'b0 || done !== 1'b0 || wr_q.size() !== base) begin
         n_fail++;
         $display("FAIL overflow: err=%0b core_rstn=%0b done=%0b writes=%0d, required 1 0 0 0",
                  err, core_rstn, done, wr_q.size() - base);
      end
      pulse_start();
      n_chk++;
      if (err !== 1'b0 || bus.rx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL err_restart: err=%0b rx_ready=%0b, required 0 1", err, bus.rx_ready);
      end
      // Complete a legal load out of the restarted header phase.
      run_load(32'd1, '{32'h0000_0093}, 1'b0);
      n_chk++;
      if (done !== 1'b1 || wr_q.size() - base !== 1) begin
         n_fail++;
         $display("FAIL err_recover: done=%0b writes=%0d, required 1 1", done, wr_q.size() - base);
      end
   endtask

   task automatic test_gaps();
      word_q_t words = '{$urandom, $urandom};
      int b0, b1;
      b0 = wr_q.size();
      pulse_start();
      run_load(32'd2, words, 1'b0);
      b1 = wr_q.size();
      pulse_start();
      run_load(32'd2, words, 1'b1);
      n_chk++;
      if (b1 - b0 !== 2 || wr_q.size() - b1 !== 2) begin
         n_fail++;
         $display("FAIL gaps_count: plain=%0d gapped=%0d, required 2 2", b1 - b0, wr_q.size() - b1);
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (wr_q[b1+i].addr !== i || wr_q[b1+i].data !== words[i] ||
                wr_q[b0+i].addr !== i || wr_q[b0+i].data !== words[i]) begin
               n_fail++;
               $display("FAIL gaps_write%0d: gapped addr=%0d data=%h plain addr=%0d data=%h, required addr=%0d data=%h",
                        i, wr_q[b1+i].addr, wr_q[b1+i].data, wr_q[b0+i].addr, wr_q[b0+i].data, i, words[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 5; it++) begin
         int      len  = $urandom_range(1, 6);
         bit      gaps = 1'($urandom_range(0, 1));
         word_q_t words;
         int      base = wr_q.size();
         int      bad  = 0;
         for (int i = 0; i < len; i++) words.push_back($urandom);
         pulse_start();
         run_load(len, words, gaps);
         n_chk++;
         if (wr_q.size() - base !== len) begin
            n_fail++;
            $display("FAIL rand%0d_count: writes=%0d, required %0d", it, wr_q.size() - base, len);
         end else begin
            for (int i = 0; i < len; i++)
               if (wr_q[base+i].addr !== i || wr_q[base+i].data !== words[i]) bad++;
            n_chk++;
            if (bad !== 0) begin
               n_fail++;
               $display("FAIL rand%0d_data: %0d wrong writes, required 0", it, bad);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int base;
      pulse_start();
      send_word(32'd2, 1'b0);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h5A, 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      n_chk++;
      if ({bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rstn, done, err} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: ready=%0b we=%0b addr=%0h wdata=%h core_rstn=%0b done=%0b err=%0b, required all 0",
                  bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, core_rstn, done, err);
      end
      bus.rx_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      base = wr_q.size();
      pulse_start();
      run_load(32'd1, '{32'hCAFE_F00D}, 1'b0);
      n_chk++;
      if (wr_q.size() - base !== 1 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reload_count: writes=%0d done=%0b, required 1 1", wr_q.size() - base, done);
      end else begin
         n_chk++;
         if (wr_q[base].addr !== 0 || wr_q[base].data !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL mid_reload_write: addr=%0d data=%h, required 0 cafef00d", wr_q[base].addr, wr_q[base].data);
         end
      end
   endtask

   task automatic test_reload();
      int base = wr_q.size();
      n_chk++;
      if (core_rstn !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_pre: core_rstn=%0b, required 1", core_rstn);
      end
      pulse_start();
      n_chk++;
      if (core_rstn !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reload_fall: core_rstn=%0b done=%0b, required 0 0", core_rstn, done);
      end
      run_load(32'd1, '{32'hDEADBEEF}, 1'b0);
      n_chk++;
      if (wr_q.size() - base !== 1 || core_rstn !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_end: writes=%0d core_rstn=%0b, required 1 1", wr_q.size() - base, core_rstn);
      end else begin
         n_chk++;
         if (wr_q[base].addr !== 0 || wr_q[base].data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL reload_write: addr=%0d data=%h, required 0 deadbeef", wr_q[base].addr, wr_q[base].data);
         end
      end
   endtask

   task automatic test_full_depth();
      word_q_t words;
      int base = wr_q.size();
      int bad  = 0;
      for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
      pulse_start();
      run_load(DEPTH, words, 1'b0);
      n_chk++;
      if (wr_q.size() - base !== DEPTH || done !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL full_count: writes=%0d done=%0b err=%0b, required %0d 1 0",
                  wr_q.size() - base, done, err, DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (wr_q[base+i].addr !== i || wr_q[base+i].data !== words[i]) bad++;
         n_chk++;
         if (bad !== 0 || wr_q[base+DEPTH-1].addr !== DEPTH - 1) begin
            n_fail++;
            $display("FAIL full_data: %0d wrong writes, last addr=%0d, required 0 and %0d",
                     bad, wr_q[base+DEPTH-1].addr, DEPTH - 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_len_zero();
      test_len_overflow();
      test_gaps();
      test_random();
      test_reset_mid();
      test_reload();
      test_full_depth();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_imem_loader.md
Name: riscv_imem_loader

Overview:
Writer side of the instruction memory. Receives a program image as a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives a single-port write interface (one word per write) into the instruction memory array. Holds the core in reset while a load is in progress and releases it when the load completes. Sits between the debug/UART byte receiver and the imem write port in the top level.

Parameters:
XLEN, `XLEN (32), data word width; the image format requires 32.
IMEM_ADDR_BIT, `IMEM_ADDR_BIT (12), imem byte-address width; depth DEPTH = 2**(IMEM_ADDR_BIT-2) words.

Ports:
i_clk  input  1  system clock
i_rstn  input  1  asynchronous active-low reset
i_start  input  1  single-cycle pulse that begins a load; accepted only in IDLE, DONE or ERR
i_rx_data  input  8  stream byte
i_rx_valid  input  1  i_rx_data valid
o_rx_ready  output  1  loader accepts a byte this cycle
o_imem_we  output  1  imem write strobe, one cycle per word
o_imem_addr  output  IMEM_ADDR_BIT-2  imem word address
o_imem_wdata  output  XLEN  imem write word
o_core_rstn  output  1  active-low core reset; high only in DONE
o_done  output  1  load completed successfully
o_err  output  1  header length exceeded DEPTH

Behaviour:
- Clock and reset: one clock, i_clk. i_rstn is asynchronous and active-low. Asserting it at any time, including mid-load, forces state IDLE and clears all registers.
- Reset values: o_rx_ready=0, o_imem_we=0, o_imem_addr=0, o_imem_wdata=0, o_core_rstn=0, o_done=0, o_err=0.
- Byte transfer: a byte is accepted only on a rising edge where i_rx_valid and o_rx_ready are both 1. o_rx_ready is a registered function of state only and does not depend on i_rx_valid.
- Image format: 4-byte little-endian word count LEN, followed by LEN words of 4 bytes each, little-endian. Accepted byte k (k=0..3) within a word goes to bits [8k+7:8k].
- States:
  - IDLE: ready=0. On i_start -> LEN_RX; byte counter cleared.
  - LEN_RX: ready=1. After the 4th accepted byte:
    - LEN==0 -> DONE.
    - LEN>DEPTH -> ERR.
    - otherwise -> DATA_RX, with word address and word count set to 0.
  - DATA_RX: ready=1. After the 4th accepted byte -> WR. Ready drops to 0 in the cycle WR is entered.
  - WR: o_imem_we=1 for exactly one cycle, with o_imem_addr = current word index and o_imem_wdata = assembled word.
    - Next cycle: address +1 and count +1.
    - If the count reached LEN -> DONE, else -> DATA_RX.
  - DONE: o_done=1 and o_core_rstn=1, held until i_start. On i_start -> LEN_RX, with o_done=0 and o_core_rstn=0 from the next cycle (reload).
  - ERR: o_err=1 and o_core_rstn=0, held until i_start -> LEN_RX (o_err cleared).
- i_start is ignored in LEN_RX, DATA_RX and WR.
- While i_rx_valid=0 the loader waits indefinitely. There is no timeout.
- Throughput: at most one word per 5 cycles (4 accept cycles + 1 write cycle).
- Address range: the word address never exceeds DEPTH-1, guaranteed by the length check. LEN==DEPTH is legal and fills the whole memory.
- o_imem_addr and o_imem_wdata are only meaningful while o_imem_we=1. They hold their last value otherwise.

Decomposition:
- Shared config header (riscv_configs.v) supplies `XLEN and `IMEM_ADDR_BIT.
- State encodings are localparams in a shared loader defines include, so the debug top can decode the state.
- One natural sub-module: riscv_byte2word, a 4-byte little-endian assembler with a byte counter and a word_valid pulse. It is reused for both the length header and the data words.

Test Plan:
- Reset then i_start; stream 01 00 00 00 / 13 05 A0 00 -> one o_imem_we at addr 0 with wdata 0x00A00513; then o_done=1 and o_core_rstn=1.
- LEN=3, words 0x11111111, 0x22222222, 0x33333333, i_rx_valid held 1 -> writes at addr 0,1,2 spaced exactly 5 cycles apart; o_rx_ready=0 during each WR cycle.
- LEN=0 -> no write; DONE entered the cycle after the 4th header byte. LEN=DEPTH+1 -> o_err=1, o_core_rstn stays 0, no writes.
- Random i_rx_valid gaps (50% duty) with LEN=2 -> identical write data and addresses to the gap-free case; no byte lost or duplicated.
- Assert i_rstn mid-word during DATA_RX -> all outputs return to reset values immediately; a new i_start reloads correctly from addr 0.
- In DONE, pulse i_start and load LEN=1 word 0xDEADBEEF -> o_core_rstn falls the next cycle, the write goes to addr 0, then o_core_rstn returns high.
